// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC capture path: controller state encoding
// and the upper bound used to build the missed-trigger saturation value.
package adc_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } cap_state_t;

    // Counters up to this width are supported; each user slices its own width.
    localparam int MISS_CNT_MAX_BITS = 32;
    localparam logic [MISS_CNT_MAX_BITS-1:0] TRIG_MISS_SAT = '1;

endpackage

// File: rtl/trig_edge_det.sv
// Registered rising-edge detector: rise is combinational from the current level
// and last cycle's level, so it is valid in the same cycle the level goes high.
module trig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/adc_frame_writer.sv
// Single-buffer frame capture into the sample RAM write port: one sample in cycle n
// is written in cycle n+1; no new capture starts until the reader acks the held frame.
module adc_frame_writer #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 14,
    parameter int MISS_CNT_BITS = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Arm,
    input  logic                     Abort,
    input  logic                     Trig,
    input  logic [RAM_ADDR_BITS-1:0] Frame_len,
    input  logic [RAM_WIDTH-1:0]     Din,
    input  logic                     Din_valid,
    input  logic                     Frame_ack,
    output logic                     Wr_en,
    output logic [RAM_ADDR_BITS-1:0] Wr_Addr,
    output logic [RAM_WIDTH-1:0]     Wr_data,
    output logic                     Busy,
    output logic                     Frame_rdy,
    output logic [RAM_ADDR_BITS-1:0] Frame_last,
    output logic [MISS_CNT_BITS-1:0] Trig_miss
);

    import adc_cap_pkg::*;

    localparam logic [MISS_CNT_BITS-1:0] MISS_SAT = TRIG_MISS_SAT[MISS_CNT_BITS-1:0];

    cap_state_t               state, state_n;
    logic [RAM_ADDR_BITS-1:0] len_q, len_n;
    logic [RAM_ADDR_BITS-1:0] addr, addr_n;
    logic                     wr_en_n;
    logic [RAM_ADDR_BITS-1:0] wr_addr_n;
    logic [RAM_WIDTH-1:0]     wr_data_n;
    logic                     rdy_n;
    logic [RAM_ADDR_BITS-1:0] last_n;
    logic [MISS_CNT_BITS-1:0] miss_n;
    logic                     trig_rise;

    trig_edge_det u_trig_edge (
        .clk   (Clk),
        .rst   (Rst),
        .level (Trig),
        .rise  (trig_rise)
    );

    assign Busy = (state == ARMED) || (state == CAPTURE);

    always_comb begin
        state_n   = state;
        len_n     = len_q;
        addr_n    = addr;
        wr_en_n   = 1'b0;
        wr_addr_n = Wr_Addr;
        wr_data_n = Wr_data;
        rdy_n     = Frame_rdy;
        last_n    = Frame_last;
        miss_n    = Trig_miss;

        if (trig_rise && (state == CAPTURE || state == HOLD) && Trig_miss != MISS_SAT) begin
            miss_n = Trig_miss + 1'b1;
        end

        if (Abort) begin
            state_n = IDLE;
            rdy_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Arm) begin
                        state_n = ARMED;
                        len_n   = Frame_len;
                    end
                end
                ARMED: begin
                    if (trig_rise) begin
                        state_n = CAPTURE;
                        addr_n  = '0;
                    end
                end
                CAPTURE: begin
                    if (Din_valid) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = addr;
                        wr_data_n = Din;
                        // Last write ends the capture, so addr never wraps on a full-RAM frame.
                        if (addr == len_q) begin
                            state_n = HOLD;
                            last_n  = len_q;
                        end else begin
                            addr_n = addr + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Frame_rdy lags HOLD entry by one cycle so the final write has landed.
                    if (Frame_ack) begin
                        state_n = IDLE;
                        rdy_n   = 1'b0;
                    end else begin
                        rdy_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            len_q      <= '0;
            addr       <= '0;
            Wr_en      <= 1'b0;
            Wr_Addr    <= '0;
            Wr_data    <= '0;
            Frame_rdy  <= 1'b0;
            Frame_last <= '0;
            Trig_miss  <= '0;
        end else begin
            state      <= state_n;
            len_q      <= len_n;
            addr       <= addr_n;
            Wr_en      <= wr_en_n;
            Wr_Addr    <= wr_addr_n;
            Wr_data    <= wr_data_n;
            Frame_rdy  <= rdy_n;
            Frame_last <= last_n;
            Trig_miss  <= miss_n;
        end
    end

endmodule

// File: tb/tb_adc_frame_writer.sv
// Bench for adc_frame_writer: table of capture scenarios plus hand-written abort/reset sequences;
// every RAM write is checked against a queue of expected {addr, data} pushed at drive time.
module tb_adc_frame_writer;

    logic        Clk;
    logic        Rst;
    logic        Arm;
    logic        Abort;
    logic        Trig;
    logic [13:0] Frame_len;
    logic [7:0]  Din;
    logic        Din_valid;
    logic        Frame_ack;
    logic        Wr_en;
    logic [13:0] Wr_Addr;
    logic [7:0]  Wr_data;
    logic        Busy;
    logic        Frame_rdy;
    logic [13:0] Frame_last;
    logic [7:0]  Trig_miss;

    adc_frame_writer #(
        .RAM_WIDTH     (8),
        .RAM_ADDR_BITS (14),
        .MISS_CNT_BITS (8)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Arm        (Arm),
        .Abort      (Abort),
        .Trig       (Trig),
        .Frame_len  (Frame_len),
        .Din        (Din),
        .Din_valid  (Din_valid),
        .Frame_ack  (Frame_ack),
        .Wr_en      (Wr_en),
        .Wr_Addr    (Wr_Addr),
        .Wr_data    (Wr_data),
        .Busy       (Busy),
        .Frame_rdy  (Frame_rdy),
        .Frame_last (Frame_last),
        .Trig_miss  (Trig_miss)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [13:0] len;
        logic [7:0]  din0;
        logic [3:0]  vpat;
        bit          trig_pre;
        int          cap_edges;
        int          hold_edges;
        bit          ack_arm;
    } cap_vec_t;

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] exp_miss = 8'h00;
    cap_vec_t   vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic sat_inc();
        if (exp_miss != 8'hFF) exp_miss = exp_miss + 8'd1;
    endtask

    // Every write the DUT makes must match the oldest expected entry.
    always @(negedge Clk) begin
        if (!Rst && Wr_en) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_write: Wr_Addr=%0h Wr_data=%0h, required no write (t=%0t)",
                         Wr_Addr, Wr_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", Wr_Addr, mon_e.addr);
                check("wr_data", Wr_data, mon_e.data);
            end
        end
    end

    task automatic run_capture(input cap_vec_t v);
        int k;
        int cyc;
        if (v.trig_pre) begin
            Trig = 1'b1;
            tick();
            tick();
        end
        Frame_len = v.len;
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        Frame_len = ~v.len;
        check("busy_armed", Busy, 1);
        if (v.trig_pre) begin
            Din = 8'hEE;
            Din_valid = 1'b1;
            repeat (3) tick();
            check("stale_trig_still_armed", Busy, 1);
            Trig = 1'b0;
            tick();
        end
        // Edge cycle: the sample presented here must not be written.
        Trig = 1'b1;
        Din = 8'hEE;
        Din_valid = 1'b1;
        tick();
        k = 0;
        cyc = 0;
        while (k <= int'(v.len)) begin
            Trig = (cyc < 2 * v.cap_edges) && (cyc % 2 == 1);
            if (Trig) sat_inc();
            Arm = (cyc == 0);
            Din_valid = v.vpat[cyc % 4];
            Din = v.din0 + 8'(k);
            if (Din_valid) begin
                exp_q.push_back('{addr: 14'(k), data: Din});
                k++;
            end
            tick();
            cyc++;
        end
        Arm = 1'b0;
        Trig = 1'b0;
        Din = 8'hEE;
        Din_valid = 1'b1;
        check("rdy_low_during_last_write", Frame_rdy, 0);
        check("busy_hold", Busy, 0);
        tick();
        check("frame_rdy", Frame_rdy, 1);
        check("frame_last", Frame_last, v.len);
        for (int i = 0; i < v.hold_edges; i++) begin
            Trig = 1'b1;
            sat_inc();
            tick();
            Trig = 1'b0;
            tick();
        end
        check("trig_miss", Trig_miss, exp_miss);
        Frame_ack = 1'b1;
        Arm = v.ack_arm;
        tick();
        Frame_ack = 1'b0;
        Arm = 1'b0;
        Din_valid = 1'b0;
        check("rdy_after_ack", Frame_rdy, 0);
        check("busy_after_ack", Busy, 0);
        tick();
        check("arm_with_ack_ignored", Busy, 0);
        check("writes_outstanding", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, Wr_en, 0);
        check({tag, "_wr_addr"}, Wr_Addr, 0);
        check({tag, "_wr_data"}, Wr_data, 0);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_frame_rdy"}, Frame_rdy, 0);
        check({tag, "_frame_last"}, Frame_last, 0);
        check({tag, "_trig_miss"}, Trig_miss, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cap_vec_t fin;
        //          len       din0   vpat     pre cap hold ack_arm
        vecs[0] = '{14'd3,    8'h10, 4'b1111, 0,  0,  0,   0};
        vecs[1] = '{14'd3,    8'h20, 4'b0101, 0,  0,  0,   1};
        vecs[2] = '{14'd0,    8'h55, 4'b1111, 0,  0,  0,   0};
        vecs[3] = '{14'd7,    8'h30, 4'b1111, 1,  2,  1,   0};
        vecs[4] = '{14'd5,    8'hA0, 4'b0011, 0,  0,  300, 1};
        vecs[5] = '{14'h3FFF, 8'h00, 4'b1111, 0,  0,  0,   0};

        Rst = 1'b1;
        Arm = 1'b0;
        Abort = 1'b0;
        Trig = 1'b0;
        Frame_len = '0;
        Din = '0;
        Din_valid = 1'b0;
        Frame_ack = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        tick();

        foreach (vecs[i]) run_capture(vecs[i]);

        // Abort two samples into a length-8 capture.
        Frame_len = 14'd7;
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        Frame_ack = 1'b1;
        tick();
        Frame_ack = 1'b0;
        check("ack_outside_hold_ignored", Busy, 1);
        Trig = 1'b1;
        Din = 8'hEE;
        Din_valid = 1'b1;
        tick();
        Trig = 1'b0;
        Din = 8'h70;
        exp_q.push_back('{addr: 14'd0, data: 8'h70});
        tick();
        Din = 8'h71;
        exp_q.push_back('{addr: 14'd1, data: 8'h71});
        tick();
        Abort = 1'b1;
        Din = 8'h72;
        tick();
        Abort = 1'b0;
        check("abort_wr_en", Wr_en, 0);
        check("abort_busy", Busy, 0);
        check("abort_frame_rdy", Frame_rdy, 0);
        for (int i = 0; i < 3; i++) begin
            Trig = 1'b1;
            tick();
            Trig = 1'b0;
            tick();
        end
        check("idle_edges_not_counted", Trig_miss, exp_miss);
        check("idle_after_abort_rdy", Frame_rdy, 0);
        Arm = 1'b1;
        Abort = 1'b1;
        tick();
        Arm = 1'b0;
        Abort = 1'b0;
        Din_valid = 1'b0;
        check("arm_abort_same_cycle", Busy, 0);
        check("abort_writes_outstanding", exp_q.size(), 0);
        fin = '{14'd2, 8'h80, 4'b1111, 0, 0, 0, 0};
        run_capture(fin);

        // Asynchronous reset in the middle of a capture.
        Frame_len = 14'd7;
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        Trig = 1'b1;
        Din_valid = 1'b1;
        tick();
        Trig = 1'b0;
        Din = 8'h90;
        exp_q.push_back('{addr: 14'd0, data: 8'h90});
        tick();
        Din = 8'h91;
        exp_q.push_back('{addr: 14'd1, data: 8'h91});
        tick();
        #2;
        Rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        exp_miss = 8'h00;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Trig = 1'b1;
            tick();
            Trig = 1'b0;
            tick();
        end
        check("post_reset_no_arm_busy", Busy, 0);
        check("post_reset_trig_miss", Trig_miss, 0);
        Din_valid = 1'b0;
        fin = '{14'd2, 8'hC0, 4'b1111, 0, 0, 0, 0};
        run_capture(fin);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/adc_frame_writer.md
Name: adc_frame_writer

Overview:
- Capture controller that sits directly upstream of the dual-port sample RAM and drives its write port.
- When armed, it waits for a trigger rising edge, then writes one frame of ADC samples (programmable length) into the RAM from address 0.
- It then holds the frame until the reader acknowledges it.
- Single-buffer scheme: no new capture can begin until the reader on the read port releases the frame.

Parameters:
- RAM_WIDTH, 8, sample/data width; must match the RAM.
- RAM_ADDR_BITS, 14, RAM address width; the maximum frame is 2**RAM_ADDR_BITS samples.
- MISS_CNT_BITS, 8, width of the saturating missed-trigger counter.

Ports:
- Clk  in  1  system clock; all logic is on its rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Arm  in  1  single-cycle request to arm a capture.
- Abort  in  1  single-cycle request to abandon any capture or held frame.
- Trig  in  1  trigger level, synchronous to Clk; the block detects the rising edge internally.
- Frame_len  in  RAM_ADDR_BITS  frame length minus 1; latched when Arm is accepted.
- Din  in  RAM_WIDTH  ADC sample.
- Din_valid  in  1  Din qualifier.
- Frame_ack  in  1  reader has finished with the frame; releases it.
- Wr_en  out  1  RAM write enable, registered.
- Wr_Addr  out  RAM_ADDR_BITS  RAM write address, registered.
- Wr_data  out  RAM_WIDTH  RAM write data, registered.
- Busy  out  1  high in ARMED or CAPTURE.
- Frame_rdy  out  1  frame complete and stable in the RAM.
- Frame_last  out  RAM_ADDR_BITS  address of the last sample written (equals len_q).
- Trig_miss  out  MISS_CNT_BITS  count of trigger edges ignored in CAPTURE/HOLD; saturates at all-ones.

Behaviour:
- Reset values: all outputs 0; state IDLE; trig_q, len_q and addr counter all 0.
- Edge detect: trig_q <= Trig each cycle. edge = Trig & ~trig_q. Trig already high when entering ARMED does not count; a fresh low-to-high transition is required.
- FSM states and transitions:
  - IDLE: Arm=1 -> ARMED; len_q <= Frame_len.
  - ARMED: edge=1 -> CAPTURE; addr <= 0. Samples valid in the edge cycle itself are not written.
  - CAPTURE: each cycle with Din_valid=1 registers Wr_en=1, Wr_Addr=addr, Wr_data=Din, then addr++. Cycles with Din_valid=0 register Wr_en=0 and addr holds. A valid sample taken when addr==len_q is the last write; state -> HOLD.
  - HOLD: Frame_rdy <= 1 on entry. Frame_ack=1 -> IDLE with Frame_rdy <= 0.
- Latency and write timing:
  - Sample presented in cycle n appears on Wr_* in cycle n+1.
  - Wr_en is a one-cycle pulse per sample; Wr_en=0 in every state except the cycle after a valid CAPTURE sample.
  - Frame_rdy rises the cycle after the final Wr_en pulse, so the RAM has taken the write.
- Frame_last <= len_q on entry to HOLD; holds until the next HOLD entry.
- Busy is combinational from the state register (ARMED or CAPTURE).
- Arm in any state other than IDLE is ignored; len_q is unchanged.
- Abort:
  - Priority over every other input.
  - Any state -> IDLE next cycle; Frame_rdy <= 0; Wr_en <= 0.
  - A write already registered in the Abort cycle still completes.
- Trig_miss increments by 1 per edge seen in CAPTURE or HOLD and saturates at 2**MISS_CNT_BITS-1.
  - Cleared only by Rst.
  - Edges in IDLE are neither counted nor captured.
- Boundary conditions:
  - Frame_len=0 gives a single-sample frame.
  - Frame_len = all-ones fills the whole RAM; addr never wraps because the last write ends the capture.
  - Arm and Abort in the same cycle: Abort wins, state stays IDLE.
  - Frame_ack outside HOLD is ignored.
  - Frame_ack and Arm in the same cycle in HOLD: go to IDLE only; Arm is ignored.
- Reset mid-operation: asynchronous return to all reset values. The frame already in the RAM is not guaranteed valid.

Decomposition:
- Shared package adc_cap_pkg holds:
  - state encoding localparams (IDLE=2'd0, ARMED=2'd1, CAPTURE=2'd2, HOLD=2'd3);
  - the saturation constant for Trig_miss.
- One natural sub-module, trig_edge_det: a registered rising-edge detector with async reset that outputs edge. Reuse it for other trigger inputs.
- Everything else stays in one FSM module.

Test Plan:
- Reset, then Arm with Frame_len=3. Trig rises, continuous Din=0x10..0x13 valid -> four Wr_en pulses at addresses 0..3 with data 0x10..0x13. Frame_rdy rises the cycle after the address-3 write; Frame_last=3; Busy=0 in HOLD.
- Same as above, but Din_valid toggles 1,0,1,0 -> Wr_en pulses only for valid cycles, addresses still contiguous 0..3, and no writes after address 3.
- Trig held high before Arm -> no capture until Trig goes low then high again. Then 2 edges during CAPTURE and 1 during HOLD -> Trig_miss=3.
- Abort two samples into a Frame_len=7 capture -> state IDLE, no Wr_en after the in-flight write, Frame_rdy stays 0. A following Arm/Trig captures again from address 0.
- Frame_len=0x3FFF (RAM_ADDR_BITS=14) -> 16384 writes, last at 0x3FFF, no wrap. Frame_ack in HOLD -> Frame_rdy=0 next cycle, state IDLE.
- Rst asserted mid-CAPTURE without a clock edge -> all outputs 0 immediately. After release, Arm is required before any write.
